ifm_window_buf: RTL
===================

# ifm_window_buf

Parametrised K×K input-feature-map window register for the convolution datapath, between the IFM SRAM reader and the PE array. It assembles a window column by column, then slides it right, left, down or up by one pixel per accepted command, taking the new edge column or row from the input. A valid/ready handshake on both sides stops an unconsumed window from being overwritten. Illegal commands are flagged rather than executed.

## Interface
- DATA_W, 8: pixel width in bits (signed).
- K, 3: window edge; legal range 2..7.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  command/data valid.
- in_ready  out  1  block can accept a command this cycle.
- in_cmd  in  3  command: 0 LOAD, 1 RIGHT, 2 LEFT, 3 DOWN, 4 UP, 7 CLEAR; 5 and 6 are illegal.
- in_data  in  K*DATA_W  one column (LOAD/RIGHT/LEFT) or row (DOWN/UP); lane i is bits [i*DATA_W +: DATA_W].
- win_data  out  K*K*DATA_W  window; element (r,c) is bits [(r*K+c)*DATA_W +: DATA_W], with r = row (0 top) and c = column (0 left).
- win_valid  out  1  window is complete and not yet consumed.
- win_ready  in  1  consumer takes the window.
- fill_cnt  out  $clog2(K+1)  number of columns loaded, 0..K.
- cmd_err  out  1  one-cycle pulse: an illegal command was accepted.

## Operation
- Accept: in_valid & in_ready. All state updates occur on the accepting clk edge.
- in_ready = (in_cmd==CLEAR) | (state!=FULL) | !win_valid | win_ready.
- States:
  - EMPTY: reset or after CLEAR; fill_cnt=0.
  - FILLING: 0 < fill_cnt < K.
  - FULL: fill_cnt=K.
- LOAD in EMPTY or FILLING:
  - in_data lane r is written to element (r, fill_cnt); fill_cnt increments.
  - When fill_cnt reaches K: go to FULL and set win_valid.
- LOAD in FULL restarts the fill:
  - lane r is written to (r,0); fill_cnt=1; state goes to FILLING; win_valid clears.
  - Columns 1..K-1 keep stale data until overwritten.
- Shift commands are legal only in FULL. Each sets win_valid.
  - RIGHT: (r,c) ← (r,c+1); (r,K-1) ← lane r.
  - LEFT: (r,c) ← (r,c-1); (r,0) ← lane r.
  - DOWN: (r,c) ← (r+1,c); (K-1,c) ← lane c.
  - UP: (r,c) ← (r-1,c); (0,c) ← lane c.
- CLEAR:
  - Zeroes all elements; fill_cnt=0; state goes to EMPTY; win_valid=0.
  - Always accepted, in any state.
- Errors:
  - A shift in EMPTY/FILLING, or cmd 5/6, is accepted with no state or data change.
  - cmd_err is high for the following cycle.
- Consumption: win_valid & win_ready clears win_valid, unless a shift is accepted in the same cycle. In that case win_valid stays 1 and win_data holds the new window.
- win_data is a registered output and changes only on accepted LOAD, shift or CLEAR.
- Pixel values are not interpreted; all moves are bit copies. Sign is preserved.

## Timing
- Reset (sync, rst=1 at a clk edge) gives:
  - win_data=0, win_valid=0, fill_cnt=0, cmd_err=0, state EMPTY.
  - in_ready then follows its combinational equation (1 in EMPTY).
- rst overrides any command accepted in the same cycle. Reset during FILLING discards the partial window.
- Latency: command accepted at edge N gives the updated win_data, fill_cnt, win_valid and cmd_err visible after edge N.
- First full window: K accepted LOADs. win_valid rises after the K-th accept edge.
- Throughput: one command per cycle when the consumer holds win_ready=1.
- Back-pressure: in FULL with win_valid=1 and win_ready=0, in_ready=0 for every non-CLEAR command. in_data and in_cmd are ignored.
- in_ready is combinational from in_cmd, win_valid, win_ready and state. No combinational path exists from in_data to any output.
- in_cmd/in_data must be stable while in_valid=1 and in_ready=0.

## Test plan
- Fill (K=3, DATA_W=8):
  - Stimulus: LOAD columns {01,02,03}, {04,05,06}, {07,08,09} (lane0 first).
  - Response: after the 3rd accept, win_valid=1, fill_cnt=3, row0 = 01,04,07, row2 = 03,06,09.
- RIGHT then LEFT:
  - From the fill state, RIGHT with {0A,0B,0C} gives row0 = 04,07,0A.
  - Then LEFT with {01,02,03} restores the original window.
- DOWN then UP:
  - DOWN with {F0,F1,F2} gives row2 = F0,F1,F2 and row0 = 02,05,08.
  - Then UP with {01,04,07} restores the original window.
  - Check that signed values such as F0 are preserved.
- Back-pressure:
  - Stimulus: FULL state, win_ready=0, RIGHT presented for 4 cycles.
  - Response: in_ready=0 and win_data unchanged.
  - Then raise win_ready: accepted in the same cycle, and win_valid stays 1.
- Errors:
  - RIGHT while fill_cnt=1 gives cmd_err for one cycle with window and fill_cnt unchanged.
  - cmd=5 in FULL gives cmd_err with no change.
  - CLEAR with win_valid=1, win_ready=0 is accepted and zeroes everything.
- Reset:
  - rst asserted for 1 cycle after 2 LOADs: all outputs return to 0.
  - A LOAD accepted in the rst cycle is discarded.
  - Three new LOADs then yield win_valid=1.

Source files
------------

// File: rtl/ifm_window_buf.sv
// K x K input-feature-map window register: column-wise fill, then one-pixel
// slides in any direction, with valid/ready on both the command and window sides.
module ifm_window_buf #(
  parameter int DATA_W = 8,
  parameter int K      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_cmd,
  input  logic [K*DATA_W-1:0]       in_data,
  output logic [K*K*DATA_W-1:0]     win_data,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [$clog2(K+1)-1:0]    fill_cnt,
  output logic                      cmd_err
);

  localparam int CW = $clog2(K+1);

  localparam logic [2:0] CMD_LOAD  = 3'd0;
  localparam logic [2:0] CMD_RIGHT = 3'd1;
  localparam logic [2:0] CMD_LEFT  = 3'd2;
  localparam logic [2:0] CMD_DOWN  = 3'd3;
  localparam logic [2:0] CMD_UP    = 3'd4;
  localparam logic [2:0] CMD_CLEAR = 3'd7;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILLING,
    S_FULL
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] win  [K][K];
  logic [DATA_W-1:0] lane [K];
  logic              accept;

  for (genvar gi = 0; gi < K; gi++) begin : g_lane
    assign lane[gi] = in_data[gi*DATA_W +: DATA_W];
  end

  for (genvar gr = 0; gr < K; gr++) begin : g_row
    for (genvar gc = 0; gc < K; gc++) begin : g_col
      assign win_data[(gr*K+gc)*DATA_W +: DATA_W] = win[gr][gc];
    end
  end

  // CLEAR always gets through so a stalled consumer can never wedge the block.
  assign in_ready = (in_cmd == CMD_CLEAR) || (state != S_FULL) || !win_valid || win_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_EMPTY;
      fill_cnt  <= '0;
      win_valid <= 1'b0;
      cmd_err   <= 1'b0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win[r][c] <= '0;
    end else begin
      cmd_err <= 1'b0;
      // Consumption; an accepted shift below re-asserts valid for the new window.
      if (win_valid && win_ready)
        win_valid <= 1'b0;
      if (accept) begin
        case (in_cmd)
          CMD_LOAD: begin
            if (state == S_FULL) begin
              for (int r = 0; r < K; r++)
                win[r][0] <= lane[r];
              fill_cnt  <= CW'(1);
              state     <= S_FILLING;
              win_valid <= 1'b0;
            end else begin
              for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                  if (c == int'(fill_cnt))
                    win[r][c] <= lane[r];
              fill_cnt <= fill_cnt + CW'(1);
              if (fill_cnt == CW'(K-1)) begin
                state     <= S_FULL;
                win_valid <= 1'b1;
              end else begin
                state <= S_FILLING;
              end
            end
          end
          CMD_RIGHT: begin
            if (state == S_FULL) begin
              for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K-1; c++)
                  win[r][c] <= win[r][c+1];
                win[r][K-1] <= lane[r];
              end
              win_valid <= 1'b1;
            end else begin
              cmd_err <= 1'b1;
            end
          end
          CMD_LEFT: begin
            if (state == S_FULL) begin
              for (int r = 0; r < K; r++) begin
                for (int c = 1; c < K; c++)
                  win[r][c] <= win[r][c-1];
                win[r][0] <= lane[r];
              end
              win_valid <= 1'b1;
            end else begin
              cmd_err <= 1'b1;
            end
          end
          CMD_DOWN: begin
            if (state == S_FULL) begin
              for (int c = 0; c < K; c++) begin
                for (int r = 0; r < K-1; r++)
                  win[r][c] <= win[r+1][c];
                win[K-1][c] <= lane[c];
              end
              win_valid <= 1'b1;
            end else begin
              cmd_err <= 1'b1;
            end
          end
          CMD_UP: begin
            if (state == S_FULL) begin
              for (int c = 0; c < K; c++) begin
                for (int r = 1; r < K; r++)
                  win[r][c] <= win[r-1][c];
                win[0][c] <= lane[c];
              end
              win_valid <= 1'b1;
            end else begin
              cmd_err <= 1'b1;
            end
          end
          CMD_CLEAR: begin
            for (int r = 0; r < K; r++)
              for (int c = 0; c < K; c++)
                win[r][c] <= '0;
            fill_cnt  <= '0;
            state     <= S_EMPTY;
            win_valid <= 1'b0;
          end
          default: begin
            cmd_err <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
